// File: rtl/regfile_arbiter.sv
// Arbitrates the single register-file port set between the core pipeline and
// the debug module; core wins by default, debug is forced through after starvation.
module regfile_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_re,
    input  logic [3:0]  core_rs1,
    input  logic [3:0]  core_rs2,
    input  logic        core_we,
    input  logic [3:0]  core_rd,
    input  logic [31:0] core_wdata,
    output logic        core_stall,
    input  logic        dbg_req,
    input  logic        dbg_wr,
    input  logic [3:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic        rf_re,
    output logic        rf_we,
    output logic [3:0]  rf_rs1,
    output logic [3:0]  rf_rs2,
    output logic [3:0]  rf_rd,
    output logic [31:0] rf_wdata,
    input  logic [31:0] rf_rdata1
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              ack_q, ack_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rd_q, rd_d;
    logic              zero_q, zero_d;
    logic              core_active, starve_hit, grant;

    // A zero limit would make the threshold compare trivially true.
    generate
        if (STARVE_LIMIT == 0) begin : g_nolimit
            assign starve_hit = 1'b1;
        end else begin : g_limit
            assign starve_hit = (starve_q >= LIMIT);
        end
    endgenerate

    assign core_active = core_re | core_we;
    assign grant       = !reset && (state_q == IDLE) && dbg_req && (!core_active || starve_hit);
    assign core_stall  = grant & core_active;
    assign dbg_ack     = ack_q;
    assign dbg_rdata   = rdata_q;

    always_comb begin
        rf_re    = 1'b0;
        rf_we    = 1'b0;
        rf_rs1   = '0;
        rf_rs2   = '0;
        rf_rd    = '0;
        rf_wdata = '0;
        if (grant) begin
            rf_re    = !dbg_wr;
            rf_we    = dbg_wr;
            rf_rs1   = dbg_addr;
            rf_rd    = dbg_addr;
            rf_wdata = dbg_wdata;
        end else if (!reset) begin
            rf_re    = core_re;
            rf_we    = core_we;
            rf_rs1   = core_rs1;
            rf_rs2   = core_rs2;
            rf_rd    = core_rd;
            rf_wdata = core_wdata;
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        ack_d    = 1'b0;
        rdata_d  = rdata_q;
        rd_d     = rd_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d  = WAIT;
                    starve_d = '0;
                    rd_d     = !dbg_wr;
                    zero_d   = (dbg_addr == 4'd0);
                end else if (dbg_req) begin
                    starve_d = starve_hit ? starve_q : starve_q + 1'b1;
                end else begin
                    starve_d = '0;
                end
            end
            // Read data is sampled here, before any core write in this cycle lands.
            WAIT: begin
                if (rd_q) rdata_d = zero_q ? 32'd0 : rf_rdata1;
                ack_d   = 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            starve_q <= '0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            rd_q     <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            rd_q     <= rd_d;
            zero_q   <= zero_d;
        end
    end

endmodule
